// File: rtl/pc_fetch_gen.sv
// -----------------------------------------------------------------------------
// pc_fetch_gen
//   IF-stage program-counter generator with a valid/ready fetch handshake
//   toward the instruction memory port.
//   - Keeps req_valid and pc stable from the first cycle req_valid is high
//     until that request is accepted (fire).
//   - Queues one redirect (flush or branch) that arrives while a request is
//     held. It is applied on the cycle after the fire.
//   - Marks the accepted beat as wrong-path (fetch_discard) when a flush was
//     queued behind it.
//
// Ports
//   clk                 in   1       clock, rising edge
//   reset               in   1       asynchronous reset, active low
//   stall               in   1       1 = do not launch a new fetch
//   branch_flag         in   1       ID-stage branch taken
//   branch_target_addr  in   ADDR_W  branch target
//   flush               in   1       exception/eret flush
//   except_pc           in   ADDR_W  flush target
//   req_ready           in   1       memory accepts the request this cycle
//   req_valid           out  1       fetch request valid
//   pc                  out  ADDR_W  fetch address (= request address)
//   fetch_discard       out  1       accepted beat is wrong-path; drop it
//   fetch_adel          out  1       misaligned fetch address
//
// Build option
//   PC_ALIGN_CHECK_EN : when defined, fetch_adel flags a valid request whose
//                       pc is not a multiple of INST_BYTES. When undefined,
//                       fetch_adel is tied low and no alignment logic exists.
// -----------------------------------------------------------------------------
module pc_fetch_gen #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = 32'hbfc00000,
  parameter int                INST_BYTES = 4,
  parameter int                BOOT_DELAY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target_addr,
  input  logic              flush,
  input  logic [ADDR_W-1:0] except_pc,
  input  logic              req_ready,
  output logic              req_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_discard,
  output logic              fetch_adel
);

  localparam int CNT_W = (BOOT_DELAY < 2) ? 1 : $clog2(BOOT_DELAY + 1);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INST_BYTES);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  boot_cnt_q, boot_cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              held_q, held_d;
  logic              pend_v_q, pend_v_d;
  logic              pend_flush_q, pend_flush_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

  logic              fire;
  logic              hold;

  // ---------------------------------------------------------------------------
  // State register (and all other flops)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_BOOT;
      boot_cnt_q   <= CNT_W'(BOOT_DELAY);
      pc_q         <= RESET_ADDR;
      held_q       <= 1'b0;
      pend_v_q     <= 1'b0;
      pend_flush_q <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      boot_cnt_q   <= boot_cnt_d;
      pc_q         <= pc_d;
      held_q       <= held_d;
      pend_v_q     <= pend_v_d;
      pend_flush_q <= pend_flush_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: BOOT lasts exactly BOOT_DELAY cycles, RUN is terminal.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q != '0) begin
          boot_cnt_d = boot_cnt_q - CNT_W'(1);
        end
        // Leave BOOT on the cycle the counter steps from 1 to 0.
        if (boot_cnt_q <= CNT_W'(1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: handshake qualifiers
  // ---------------------------------------------------------------------------
  always_comb begin
    req_valid = 1'b0;
    fire      = 1'b0;
    hold      = 1'b0;
    if (state_q == ST_RUN) begin
      // A held request stays valid even when stall rises.
      req_valid = ~stall | held_q;
      fire      = req_valid & req_ready;
      hold      = req_valid & ~req_ready;
    end
  end

  // ---------------------------------------------------------------------------
  // PC / pending-redirect datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d         = pc_q;
    pend_v_d     = pend_v_q;
    pend_flush_d = pend_flush_q;
    pend_addr_d  = pend_addr_q;
    held_d       = hold;

    if (state_q == ST_RUN) begin
      if (flush && hold) begin
        // A queued flush overrides any queued branch.
        pend_addr_d  = except_pc;
        pend_v_d     = 1'b1;
        pend_flush_d = 1'b1;
      end else if (flush) begin
        pc_d         = except_pc;
        pend_v_d     = 1'b0;
        pend_flush_d = 1'b0;
      end else if (fire) begin
        if (pend_v_q) begin
          pc_d = pend_addr_q;
        end else if (branch_flag) begin
          pc_d = branch_target_addr;
        end else begin
          pc_d = pc_q + PC_STEP;  // wraps modulo 2^ADDR_W
        end
        pend_v_d     = 1'b0;
        pend_flush_d = 1'b0;
      end else if (branch_flag && hold) begin
        // A branch behind a queued flush is wrong-path and is dropped.
        if (!pend_flush_q) begin
          pend_addr_d = branch_target_addr;
          pend_v_d    = 1'b1;
        end
      end
      // A branch seen while stalled and not held is ignored: ID presents it
      // again once the stall clears.
    end
  end

  assign pc            = pc_q;
  assign fetch_discard = fire & pend_flush_q;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);
  // The misaligned request is still issued; this only tags the beat.
  assign fetch_adel = req_valid & ((pc_q & ALIGN_MASK) != '0);
`else
  assign fetch_adel = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_gen
//   Directed test of pc_fetch_gen: boot sequence, held handshake, queued
//   branch and flush, stalled flush, asynchronous reset mid-hold, PC wrap and
//   the misaligned-address flag.
// -----------------------------------------------------------------------------
module tb_pc_fetch_gen;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_target_addr;
  logic        flush;
  logic [31:0] except_pc;
  logic        req_ready;
  logic        req_valid;
  logic [31:0] pc;
  logic        fetch_discard;
  logic        fetch_adel;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic ADEL_EXP = 1'b1;
`else
  localparam logic ADEL_EXP = 1'b0;
`endif

  pc_fetch_gen dut (
    .clk                (clk),
    .reset              (reset),
    .stall              (stall),
    .branch_flag        (branch_flag),
    .branch_target_addr (branch_target_addr),
    .flush              (flush),
    .except_pc          (except_pc),
    .req_ready          (req_ready),
    .req_valid          (req_valid),
    .pc                 (pc),
    .fetch_discard      (fetch_discard),
    .fetch_adel         (fetch_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One transaction line per call, four comparisons.
  task automatic chk_out(input string tag, input logic v, input logic [31:0] p,
                         input logic d, input logic a);
    check({tag, ".valid"},   {31'd0, req_valid},     {31'd0, v});
    check({tag, ".pc"},      pc,                     p);
    check({tag, ".discard"}, {31'd0, fetch_discard}, {31'd0, d});
    check({tag, ".adel"},    {31'd0, fetch_adel},    {31'd0, a});
    $display("[TB] %-12s valid=%0b pc=%h discard=%0b adel=%0b", tag, req_valid, pc,
             fetch_discard, fetch_adel);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; stall = 1'b0; branch_flag = 1'b0; flush = 1'b0;
    branch_target_addr = '0; except_pc = '0; req_ready = 1'b1;

    // T1: reset, boot, sequential fetch
    repeat (3) nxt();
    #1 chk_out("rst", 1'b0, 32'hbfc00000, 1'b0, 1'b0);
    reset = 1'b1;
    #1 chk_out("boot", 1'b0, 32'hbfc00000, 1'b0, 1'b0);
    nxt(); #1 chk_out("t1_a", 1'b1, 32'hbfc00000, 1'b0, 1'b0);
    nxt(); #1 chk_out("t1_b", 1'b1, 32'hbfc00004, 1'b0, 1'b0);

    // T2: hold at 0xbfc00008 for 4 cycles with stall toggling
    nxt(); req_ready = 1'b0; stall = 1'b0;
    #1 chk_out("t2_h0", 1'b1, 32'hbfc00008, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      nxt(); stall = i[0];
      #1 chk_out("t2_hold", 1'b1, 32'hbfc00008, 1'b0, 1'b0);
    end
    nxt(); stall = 1'b0; req_ready = 1'b1;
    #1 chk_out("t2_fire", 1'b1, 32'hbfc00008, 1'b0, 1'b0);

    // T3: branch during hold, ready two cycles later
    nxt(); req_ready = 1'b0; branch_flag = 1'b1; branch_target_addr = 32'hbfc00100;
    #1 chk_out("t3_br", 1'b1, 32'hbfc0000c, 1'b0, 1'b0);
    nxt(); branch_flag = 1'b0;
    #1 chk_out("t3_h", 1'b1, 32'hbfc0000c, 1'b0, 1'b0);
    nxt(); req_ready = 1'b1;
    #1 chk_out("t3_fire", 1'b1, 32'hbfc0000c, 1'b0, 1'b0);

    // T4: flush then branch during one hold
    nxt(); req_ready = 1'b0; flush = 1'b1; except_pc = 32'hbfc00380;
    #1 chk_out("t3_tgt", 1'b1, 32'hbfc00100, 1'b0, 1'b0);
    nxt(); flush = 1'b0; branch_flag = 1'b1; branch_target_addr = 32'hbfc00200;
    #1 chk_out("t4_h", 1'b1, 32'hbfc00100, 1'b0, 1'b0);
    nxt(); branch_flag = 1'b0; req_ready = 1'b1;
    #1 chk_out("t4_fire", 1'b1, 32'hbfc00100, 1'b1, 1'b0);
    nxt();
    #1 chk_out("t4_tgt", 1'b1, 32'hbfc00380, 1'b0, 1'b0);

    // T5: flush while stalled and not held; stalled branch ignored
    nxt(); stall = 1'b1; flush = 1'b1; except_pc = 32'hbfc00380;
    #1 chk_out("t5_st", 1'b0, 32'hbfc00384, 1'b0, 1'b0);
    nxt(); flush = 1'b0;
    #1 chk_out("t5_a", 1'b0, 32'hbfc00380, 1'b0, 1'b0);
    nxt(); branch_flag = 1'b1; branch_target_addr = 32'hbfc00500;
    #1 chk_out("t5_b", 1'b0, 32'hbfc00380, 1'b0, 1'b0);
    nxt(); branch_flag = 1'b0; stall = 1'b0;
    #1 chk_out("t5_go", 1'b1, 32'hbfc00380, 1'b0, 1'b0);

    // T5: async reset mid-hold with a queued flush
    nxt(); req_ready = 1'b0;
    #1 chk_out("t5_h", 1'b1, 32'hbfc00384, 1'b0, 1'b0);
    nxt(); flush = 1'b1; except_pc = 32'hbfc00380;
    #1 chk_out("t5_hf", 1'b1, 32'hbfc00384, 1'b0, 1'b0);
    nxt(); flush = 1'b0;
    #2 reset = 1'b0;
    #1 chk_out("t5_rst", 1'b0, 32'hbfc00000, 1'b0, 1'b0);
    nxt(); reset = 1'b1; req_ready = 1'b1;
    #1 chk_out("t5_boot", 1'b0, 32'hbfc00000, 1'b0, 1'b0);
    nxt(); branch_flag = 1'b1; branch_target_addr = 32'hfffffffc;
    #1 chk_out("t5_reboot", 1'b1, 32'hbfc00000, 1'b0, 1'b0);

    // T6: wrap, misaligned target, flush coinciding with fire
    nxt(); branch_flag = 1'b0;
    #1 chk_out("t6_wrap_a", 1'b1, 32'hfffffffc, 1'b0, 1'b0);
    nxt(); branch_flag = 1'b1; branch_target_addr = 32'hbfc00102;
    #1 chk_out("t6_wrap_b", 1'b1, 32'h00000000, 1'b0, 1'b0);
    nxt(); branch_flag = 1'b0;
    #1 chk_out("t6_mis", 1'b1, 32'hbfc00102, 1'b0, ADEL_EXP);
    nxt(); flush = 1'b1; except_pc = 32'hbfc00380;
    #1 chk_out("t6_mis2", 1'b1, 32'hbfc00106, 1'b0, ADEL_EXP);
    nxt(); flush = 1'b0;
    #1 chk_out("t6_ff", 1'b1, 32'hbfc00380, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
